status_report_sequencer: RTL and testbench

Periodic and on-demand scheduler for the serial link. It snapshots the 8 demodulated channel outputs and the ones count, then emits a fixed 4-byte frame over a valid/ready byte handshake to the UART transmitter that drives the uart_transmit pin. It sits between the pwm_analyzer/ones_counter outputs and the UART TX, and owns when that shared transmitter is used.

---
 rtl/keis_report_pkg.sv | 27 ++
 rtl/report_period_timer.sv | 39 +++
 rtl/status_report_sequencer.sv | 134 +++++++++++++
 tb/tb_status_report_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keis_report_pkg.sv
// Shared constants for the status report sequencer: FSM state encoding,
// frame layout and the default sync byte.
package keis_report_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_STATE = 3'd2;
    localparam logic [2:0] ST_COUNT = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;

    localparam int FRAME_LEN = 4;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int BYTE_SYNC  = 0;
    localparam int BYTE_STATE = 1;
    localparam int BYTE_COUNT = 2;
    localparam int BYTE_CHK   = 3;

    // Byte states are consecutive; the checksum byte hands back to IDLE.
    function automatic logic [2:0] next_byte_state(input logic [2:0] s);
        if (s == ST_CHK) begin
            return ST_IDLE;
        end
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/report_period_timer.sv
// Free-running report period timer: counts 0..REPORT_PERIOD-1 while enabled
// and pulses tick_o for one cycle at the terminal count.
module report_period_timer #(
    parameter int REPORT_PERIOD = 100000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(REPORT_PERIOD);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REPORT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_terminal;

    assign at_terminal = (cnt_q == TERMINAL);
    assign tick_o      = enable_i && at_terminal;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || at_terminal) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/status_report_sequencer.sv
// Schedules periodic and forced status reports and streams each one as a
// 4-byte frame (sync, channels, ones count, xor checksum) over valid/ready.
//
// state | meaning
// IDLE  | no frame; waiting for a trigger or a pending request
// SYNC  | presenting the sync byte
// STATE | presenting the channel snapshot
// COUNT | presenting the ones-count snapshot
// CHK   | presenting the checksum; acceptance ends the frame
module status_report_sequencer
    import keis_report_pkg::*;
#(
    parameter int          REPORT_PERIOD  = 100000,
    parameter int          INPUT_FEATURES = 8,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic                                  enable_i,
    input  logic                                  force_i,
    input  logic [INPUT_FEATURES-1:0]             channels_i,
    input  logic [$clog2(INPUT_FEATURES+1)-1:0]   ones_i,
    output logic [7:0]                            tx_data_o,
    output logic                                  tx_valid_o,
    input  logic                                  tx_ready_i,
    output logic                                  busy_o,
    output logic                                  overrun_o,
    output logic [7:0]                            frame_count_o
);

    logic       tick;
    logic       trigger;
    logic       accept;

    logic [2:0] state_q,       state_d;
    logic       pending_q,     pending_d;
    logic       overrun_q,     overrun_d;
    logic [7:0] snap_ch_q,     snap_ch_d;
    logic [7:0] snap_cnt_q,    snap_cnt_d;
    logic [7:0] chk_q,         chk_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [7:0] tx_data_q,     tx_data_d;
    logic       tx_valid_q,    tx_valid_d;

    report_period_timer #(
        .REPORT_PERIOD (REPORT_PERIOD)
    ) u_timer (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    assign trigger = tick | force_i;
    assign accept  = tx_valid_q && tx_ready_i;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        snap_ch_d     = snap_ch_q;
        snap_cnt_d    = snap_cnt_q;
        chk_d         = chk_q;
        frame_count_d = frame_count_q;

        if (state_q == ST_IDLE) begin
            if (trigger || pending_q) begin
                state_d    = ST_SYNC;
                pending_d  = 1'b0;
                snap_ch_d  = 8'(channels_i);
                snap_cnt_d = 8'(ones_i);
                chk_d      = SYNC_BYTE ^ snap_ch_d ^ snap_cnt_d;
            end
        end else begin
            if (accept) begin
                state_d = next_byte_state(state_q);
                if (state_q == ST_CHK) begin
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            // Only one request can queue behind a frame; a second is lost.
            if (trigger) begin
                if (pending_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    // Byte outputs are registered from the next state so they line up with it.
    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SYNC:  tx_data_d = SYNC_BYTE;
            ST_STATE: tx_data_d = snap_ch_d;
            ST_COUNT: tx_data_d = snap_cnt_d;
            ST_CHK:   tx_data_d = chk_d;
            default:  tx_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            snap_ch_q     <= 8'h00;
            snap_cnt_q    <= 8'h00;
            chk_q         <= 8'h00;
            frame_count_q <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            snap_ch_q     <= snap_ch_d;
            snap_cnt_q    <= snap_cnt_d;
            chk_q         <= chk_d;
            frame_count_q <= frame_count_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign overrun_o     = overrun_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_status_report_sequencer.sv
// Scoreboard bench for status_report_sequencer: expected frame bytes are queued
// when a report is requested and checked as each byte is accepted.
module tb_status_report_sequencer;

    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       force_i;
    logic [7:0] channels_i;
    logic [3:0] ones_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       overrun_o;
    logic [7:0] frame_count_o;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_fc = 8'd0;

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    status_report_sequencer #(
        .REPORT_PERIOD  (PERIOD),
        .INPUT_FEATURES (8),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .force_i       (force_i),
        .channels_i    (channels_i),
        .ones_i        (ones_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge; outputs are observed here at negedge.
    always @(negedge clk) begin
        if (reset_i) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_vec++;
                if (!(tx_valid_o === 1'b1 && tx_data_o === hold_d)) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid_o, tx_data_o, hold_d);
                end
            end
            if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL byte_unexpected: got %02h with empty scoreboard", tx_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        n_err++;
                        $display("FAIL byte_data: got %02h required %02h", tx_data_o, e);
                    end
                end
            end
            hold_v = (tx_valid_o === 1'b1) && (tx_ready_i !== 1'b1);
            hold_d = tx_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_frame(input logic [7:0] ch, input logic [7:0] cnt);
        exp_q.push_back(8'hA5);
        exp_q.push_back(ch);
        exp_q.push_back(cnt);
        exp_q.push_back(8'hA5 ^ ch ^ cnt);
    endfunction

    task automatic check_fc(input string name);
        n_vec++;
        if (frame_count_o !== exp_fc) begin
            n_err++;
            $display("FAIL %s: frame_count=%0d required %0d", name, frame_count_o, exp_fc);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0b required %0b", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; enable_i = 1'b0; force_i = 1'b0;
        channels_i = 8'h00; ones_i = 4'd0; tx_ready_i = 1'b1;
        step(); step();
        reset_i = 1'b0;
        step();
        check_bit("reset_valid", tx_valid_o, 1'b0);
        check_bit("reset_busy", busy_o, 1'b0);
        check_bit("reset_overrun", overrun_o, 1'b0);
        check_fc("reset_frame_count");
        n_vec++;
        if (tx_data_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %02h required 00", tx_data_o);
        end
    endtask

    task automatic test_forced();
        channels_i = 8'h3C; ones_i = 4'd4; tx_ready_i = 1'b1;
        push_frame(8'h3C, 8'h04);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        check_bit("forced_latency_valid", tx_valid_o, 1'b1);
        n_vec++;
        if (tx_data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL forced_first_byte: got %02h required a5", tx_data_o);
        end
        repeat (4) step();
        exp_fc++;
        check_bit("forced_done_busy", busy_o, 1'b0);
        check_fc("forced_frame_count");
    endtask

    task automatic test_periodic();
        int rises[$];
        logic prev_v;
        channels_i = 8'h55; ones_i = 4'd4; tx_ready_i = 1'b1;
        repeat (3) push_frame(8'h55, 8'h04);
        prev_v = tx_valid_o;
        enable_i = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (tx_valid_o === 1'b1 && prev_v !== 1'b1) rises.push_back(i);
            prev_v = tx_valid_o;
        end
        enable_i = 1'b0;
        repeat (6) step();
        exp_fc += 8'd3;
        n_vec++;
        if (rises.size() != 3) begin
            n_err++;
            $display("FAIL periodic_count: %0d frame starts required 3", rises.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (rises[k] != PERIOD * (k + 1)) begin
                    n_err++;
                    $display("FAIL periodic_start%0d: cycle %0d required %0d",
                             k, rises[k], PERIOD * (k + 1));
                end
            end
        end
        check_bit("periodic_overrun", overrun_o, 1'b0);
        check_fc("periodic_frame_count");
    endtask

    task automatic test_backpressure();
        channels_i = 8'h3C; ones_i = 4'd4; tx_ready_i = 1'b0;
        push_frame(8'h3C, 8'h04);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            tx_ready_i = 1'b0;
            step();
            channels_i = 8'hFF;
            step();
            tx_ready_i = 1'b1;
            step();
        end
        exp_fc++;
        check_bit("bp_done_busy", busy_o, 1'b0);
        check_fc("bp_frame_count");
        channels_i = 8'h3C;
    endtask

    task automatic test_back_to_back();
        int budget;
        channels_i = 8'h12; ones_i = 4'd2; tx_ready_i = 1'b1;
        push_frame(8'h12, 8'h02);
        push_frame(8'h12, 8'h02);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        repeat (3) step();
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        exp_fc++;
        check_bit("b2b_gap_idle", busy_o, 1'b0);
        step();
        check_bit("b2b_restart_valid", tx_valid_o, 1'b1);
        budget = 0;
        while (busy_o === 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        exp_fc++;
        check_fc("b2b_frame_count");
        check_bit("b2b_overrun", overrun_o, 1'b0);
    endtask

    task automatic test_overrun();
        int budget;
        channels_i = 8'h81; ones_i = 4'd2; tx_ready_i = 1'b0;
        push_frame(8'h81, 8'h02);
        push_frame(8'h81, 8'h02);
        enable_i = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 29) check_bit("overrun_after_pending", overrun_o, 1'b0);
            if (i == 30) check_bit("overrun_on_second", overrun_o, 1'b1);
        end
        enable_i = 1'b0;
        tx_ready_i = 1'b1;
        exp_fc += 8'd2;
        budget = 0;
        while (frame_count_o !== exp_fc && budget < 50) begin
            step();
            budget++;
        end
        step();
        check_fc("overrun_frame_count");
        check_bit("overrun_sticky", overrun_o, 1'b1);
        check_bit("overrun_idle", busy_o, 1'b0);
    endtask

    task automatic test_reset_mid();
        channels_i = 8'h3C; ones_i = 4'd4; tx_ready_i = 1'b1;
        exp_q.push_back(8'hA5);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        step();
        tx_ready_i = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        exp_fc = 8'd0;
        check_bit("rst_mid_valid", tx_valid_o, 1'b0);
        check_bit("rst_mid_busy", busy_o, 1'b0);
        check_bit("rst_mid_overrun", overrun_o, 1'b0);
        check_fc("rst_mid_frame_count");
        tx_ready_i = 1'b1;
        push_frame(8'h3C, 8'h04);
        force_i = 1'b1;
        step();
        force_i = 1'b0;
        n_vec++;
        if (tx_data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL rst_mid_restart: got %02h required a5", tx_data_o);
        end
        repeat (4) step();
        exp_fc++;
        check_fc("rst_mid_new_frame");
    endtask

    task automatic test_wrap();
        channels_i = 8'h01; ones_i = 4'd1; tx_ready_i = 1'b1;
        for (int f = 0; f < 255; f++) begin
            push_frame(8'h01, 8'h01);
            force_i = 1'b1;
            step();
            force_i = 1'b0;
            repeat (4) step();
            exp_fc++;
            if (f == 253) check_fc("wrap_at_255");
            if (f == 254) check_fc("wrap_to_0");
        end
    endtask

    initial begin
        test_reset();
        test_forced();
        test_periodic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_wrap();
        repeat (3) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
